tff_count_sequencer: RTL and testbench
======================================

// Module: tff_count_sequencer
// PURPOSE
//  Controller that sequences a bank of WIDTH T flip-flops as a run-to-target counter.
//  The count bits change only through the per-bit T inputs.
//  The controller computes each T bit every cycle to clear, load, count up or count down,
//  and it signals completion. It sits beside the T-flop datapath as that datapath's only T source.
// PARAMETERS
//  WIDTH   4   number of T flip-flops / count bits (>=2)
// PORTS
//  clock   in   1      single clock; all state updates on rising edge
//  reset   in   1      synchronous, active-high; clears controller and every T flop
//  start   in   1      begin a run; sampled only in IDLE
//  stop    in   1      abort current run; count holds its value
//  mode    in   1      0 = count up from 0 to limit, 1 = count down from limit to 0
//  limit   in   WIDTH  target (up) or start value (down); captured on accepted start
//  count   out  WIDTH  Q vector of the T-flop bank
//  busy    out  1      high in CLEAR, LOAD, RUN
//  done    out  1      one-cycle pulse in DONE
// BEHAVIOUR
//  Reset (reset=1 at edge): state=IDLE, count=0, busy=0, done=0, lim_q=0, mode_q=0; reset overrides all other inputs.
//  States: IDLE, CLEAR, LOAD, RUN, DONE.
//  T vector t[WIDTH-1:0] by state (stop=1 in a busy state forces t=0 this cycle):
//   IDLE/DONE: t=0.
//   CLEAR: t=count (all 1 bits toggle -> count=0 next).
//   LOAD: t=count^lim_q (count=lim_q next).
//   RUN up: t[0]=1, t[i]=&count[i-1:0]; RUN down: t[0]=1, t[i]=&~count[i-1:0].
//   RUN when count==target: t=0.
//  Transitions:
//   IDLE: start&!stop -> capture lim_q<=limit, mode_q<=mode; go to CLEAR if mode=0, LOAD if mode=1.
//   CLEAR -> RUN and LOAD -> RUN, each after 1 cycle.
//   RUN: target = lim_q (up) or 0 (down); count==target -> DONE; else stay in RUN, count steps by 1.
//   DONE -> IDLE after 1 cycle; done=1 only while in DONE.
//   stop=1 in CLEAR/LOAD/RUN -> IDLE at the edge, count unchanged, no done pulse.
//   start while not IDLE is ignored; start&stop together in IDLE -> stay IDLE.
//  Latency (up, start accepted at edge k): count=0 after k+1, reaches L after k+1+L, DONE in cycle after k+2+L.
//  Down: count=lim_q after k+1, reaches 0 after k+1+lim_q, DONE in cycle after k+2+lim_q.
//  Boundaries:
//   limit=0 up, or limit=0 down: RUN lasts 1 cycle, then DONE.
//   limit=2^WIDTH-1: no wrap; the count never passes the target.
//   limit changes after capture: ignored.
//   reset mid-run: next cycle is IDLE with count=0.
// STRUCTURE
//  Package tff_seq_pkg: state enum (IDLE=0, CLEAR=1, LOAD=2, RUN=3, DONE=4), width of state register.
//  Sub-module tff_cell: one T flip-flop, ports (Q, T, clock, reset).
//   tff_cell has a synchronous active-high reset to 0.
//   It is instantiated WIDTH times in a generate loop.
//  Top level: FSM, lim_q/mode_q capture, combinational T-vector generator, target compare.
// TESTING
//  1. reset 1 cycle, start=1 mode=0 limit=5 -> count 0,1..5; done pulse 1 cycle at cycle 8 after start; busy low after.
//  2. Preload count=9 (previous down run stopped), then up run limit=3 -> CLEAR gives count=0 in 1 cycle; counts to 3; done.
//  3. mode=1 limit=12 -> LOAD count=12, then 11..0; done once; count stays 0 in IDLE.
//  4. stop asserted when count=3 in up run to 7 -> IDLE; count holds 3; no done; restart up runs from 0.
//  5. WIDTH=4, limit=15 up -> reaches 15, done, no wrap to 0; limit=0 up -> done 2 cycles after CLEAR.
//  6. reset asserted mid-RUN (count=6) -> next cycle count=0, busy=0, done=0; start during busy is ignored.

Source files
------------

// File: rtl/tff_seq_pkg.sv
// tff_seq_pkg: shared state encoding for the T-flop count sequencer
package tff_seq_pkg;
   localparam int STATE_W = 3;
   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with synchronous active-high clear
module tff_cell (
   output logic q,
   input  logic t,
   input  logic clock,
   input  logic reset
);
   // toggle when t is high, clear on reset
   always_ff @(posedge clock)
      q <= reset ? 1'b0 : q ^ t;
endmodule

// File: rtl/tff_count_sequencer.sv
// tff_count_sequencer: drives a T-flop bank as a run-to-target up/down counter
module tff_count_sequencer
   import tff_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);
   state_t           state;
   logic [WIDTH-1:0] lim_q;
   logic             mode_q;
   logic [WIDTH-1:0] up_t, dn_t, t;
   logic             at_target;

   assign at_target = count == (mode_q ? '0 : lim_q);

   // carry/borrow chains: a bit toggles when all lower bits are 1 (up) or 0 (down)
   always_comb begin
      up_t = '0;
      dn_t = '0;
      up_t[0] = 1'b1;
      dn_t[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         up_t[i] = up_t[i-1] & count[i-1];
         dn_t[i] = dn_t[i-1] & ~count[i-1];
      end
   end

   // toggle vector: stop freezes the bank, otherwise each state steers it to its goal
   always_comb
      t = stop && busy                     ? '0 :
          state == CLEAR                   ? count :
          state == LOAD                    ? count ^ lim_q :
          state == RUN && !at_target       ? (mode_q ? dn_t : up_t) : '0;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bank
      tff_cell u_cell (.q(count[g]), .t(t[g]), .clock(clock), .reset(reset));
   end

   // sequencing FSM with registered busy/done
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         lim_q  <= '0;
         mode_q <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start && !stop) begin
               lim_q  <= limit;
               mode_q <= mode;
               state  <= mode ? LOAD : CLEAR;
               busy   <= 1'b1;
            end
            CLEAR, LOAD: begin
               state <= stop ? IDLE : RUN;
               busy  <= !stop;
            end
            RUN: if (stop) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (at_target) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tff_count_sequencer.sv
// tb_tff_count_sequencer: directed checks of the T-flop count sequencer
module tb_tff_count_sequencer;
   localparam int WIDTH = 4;
   logic             clock = 1'b0;
   logic             reset, start, stop, mode;
   logic [WIDTH-1:0] limit, count;
   logic             busy, done;
   int               total = 0;
   int               bad = 0;

   tff_count_sequencer #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .mode(mode),
      .limit(limit), .count(count), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic kick(input logic m, input logic [WIDTH-1:0] l);
      start = 1'b1;
      mode  = m;
      limit = l;
      step;
      start = 1'b0;
   endtask

   task automatic expect_done(input string tag, input int cnt);
      step;
      chk({tag, "_done"}, done, 1);
      chk({tag, "_dbusy"}, busy, 0);
      chk({tag, "_dcnt"}, count, cnt);
      step;
      chk({tag, "_done_end"}, done, 0);
      chk({tag, "_hold"}, count, cnt);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0;
      step;
      reset = 1'b0;
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      // 1: up run to 5
      kick(1'b0, 4'd5);
      chk("t1_busy", busy, 1);
      step;
      chk("t1_clr", count, 0);
      for (int v = 1; v <= 5; v++) begin step; chk("t1_up", count, v); end
      expect_done("t1", 5);

      // 2: preload 9 via stopped down run, then up to 3
      kick(1'b1, 4'd9);
      step;
      chk("t2_load", count, 9);
      stop = 1'b1;
      step;
      stop = 1'b0;
      chk("t2_stopcnt", count, 9);
      chk("t2_stopbusy", busy, 0);
      kick(1'b0, 4'd3);
      chk("t2_clrstate", count, 9);
      step;
      chk("t2_clr", count, 0);
      for (int v = 1; v <= 3; v++) begin step; chk("t2_up", count, v); end
      expect_done("t2", 3);

      // 3: down from 12, limit change after capture ignored
      kick(1'b1, 4'd12);
      limit = 4'd7;
      step;
      chk("t3_load", count, 12);
      for (int v = 11; v >= 0; v--) begin step; chk("t3_dn", count, v); end
      expect_done("t3", 0);
      step;
      chk("t3_idle", count, 0);

      // 4: stop at 3 in up run to 7, then restart
      kick(1'b0, 4'd7);
      step;
      for (int v = 1; v <= 3; v++) begin step; chk("t4_up", count, v); end
      stop = 1'b1;
      step;
      stop = 1'b0;
      chk("t4_stopcnt", count, 3);
      chk("t4_stopbusy", busy, 0);
      chk("t4_nodone", done, 0);
      step;
      chk("t4_hold", count, 3);
      chk("t4_nodone2", done, 0);
      kick(1'b0, 4'd2);
      step;
      chk("t4_clr", count, 0);
      for (int v = 1; v <= 2; v++) begin step; chk("t4_up2", count, v); end
      expect_done("t4", 2);

      // 5: full-scale up with no wrap, then limit=0 both directions
      kick(1'b0, 4'd15);
      step;
      chk("t5_clr", count, 0);
      for (int v = 1; v <= 15; v++) begin step; chk("t5_up", count, v); end
      expect_done("t5", 15);
      kick(1'b0, 4'd0);
      step;
      chk("t5_zero_clr", count, 0);
      chk("t5_zero_busy", busy, 1);
      expect_done("t5z", 0);
      kick(1'b1, 4'd0);
      step;
      chk("t5_zdn_load", count, 0);
      expect_done("t5zd", 0);

      // start and stop together in IDLE stays idle
      start = 1'b1; stop = 1'b1; limit = 4'd4;
      step;
      start = 1'b0; stop = 1'b0;
      chk("ss_busy", busy, 0);
      chk("ss_count", count, 0);

      // 6: start ignored while busy, reset mid-run at 6
      kick(1'b0, 4'd10);
      step;
      for (int v = 1; v <= 6; v++) begin
         start = 1'b1; mode = 1'b1; limit = 4'd2;
         step;
         chk("t6_up", count, v);
      end
      start = 1'b0;
      chk("t6_busy", busy, 1);
      reset = 1'b1;
      step;
      reset = 1'b0;
      chk("t6_rstcnt", count, 0);
      chk("t6_rstbusy", busy, 0);
      chk("t6_rstdone", done, 0);
      step;
      chk("t6_idle", busy, 0);
      chk("t6_idlecnt", count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
